fir_decim_requant: RTL and testbench
====================================

Name: fir_decim_requant

Overview:
- Sits directly downstream of the 3-tap FIR filter and consumes its 17-bit unsigned output y.
- Keeps one of every DECIM accepted samples and requantises it to OUT_W bits with round-half-up and saturation.
- Buffers results in a small FIFO with a valid/ready handshake toward the next consumer.
- Reports sticky saturation and overflow flags.

Parameters:
- IN_W, 17: input sample width; matches the FIR output width.
- OUT_W, 8: output sample width.
- SHIFT, 9: right-shift applied in requantisation; 0 means pass-through with saturation only.
- DECIM, 2: decimation factor; must be >= 1.
- DEPTH, 4: FIFO depth; must be a power of two and >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  y_in carries a new FIR sample this cycle.
- y_in  in  IN_W  unsigned FIR output sample.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_data  out  OUT_W  FIFO head data.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sat_flag  out  1  sticky: a kept sample saturated.
- ovf_flag  out  1  sticky: a kept sample was dropped because the FIFO was full.
- clr_flags  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst=0, asynchronous): phase counter=0, pipeline valid=0, FIFO empty, out_valid=0, out_data=0, fifo_count=0, sat_flag=0, ovf_flag=0.
- Decimation:
  - Phase counter advances only on in_valid and wraps from DECIM-1 to 0.
  - A sample is kept when the phase is 0, so the first sample after reset is kept.
  - DECIM=1 keeps every sample.
- Requantisation (stage 1, registered):
  - Compute t = (y_in + 2^(SHIFT-1)) >> SHIFT in IN_W+1 bits, so the rounding add cannot wrap.
  - With SHIFT=0 there is no rounding add.
  - If t > 2^OUT_W-1, the result is 2^OUT_W-1 and sat_flag is set. Otherwise the result is t.
  - A kept sample is captured at edge k and sets pipe_valid.
- FIFO write (stage 2): pipe_valid at edge k+1 pushes into the FIFO.
  - out_valid rises after edge k+1 if the FIFO was empty.
  - Latency from accepting in_valid to out_valid is 2 cycles.
- Pop: out_valid && out_ready at an edge removes the head. out_data always shows the head and holds its last value when empty.
- Push while full:
  - If a pop occurs the same cycle, the push succeeds and the count is unchanged.
  - Otherwise the sample is dropped and ovf_flag is set.
- Simultaneous push and pop with the FIFO not full: count is unchanged and order is preserved.
- Pop when empty: no effect, no flag.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Flags:
  - Sticky until clr_flags=1 at an edge.
  - If a set event and clr_flags occur in the same cycle, set wins (flag=1).
- Reset mid-operation: immediately discards the pipeline and FIFO contents and restarts the phase at 0.
- y_in is ignored when in_valid=0. No backpressure exists toward the FIR.

Decomposition:
- Shared package fir_pkg holds FIR_OUT_W=17 (also used by the FIR) and the default OUT_W, SHIFT, DECIM and DEPTH constants.
- One sub-module, fir_out_fifo: a synchronous FIFO with the same clk/rst, parameterised by width and depth.
  - Ports: push, push_data, pop, head, count, full, empty.
  - Implements the pop-while-full push rule.
- Decimation counter, rounding/saturation and the flag logic stay in the top module.

Test Plan:
- Decimation: DECIM=2, out_ready=1, in_valid=1 with y_in=512, 1024, 1536, 2048 -> out_data=1 then 3, out_valid pulses 2 cycles after each kept input, fifo_count never exceeds 1.
- Rounding: DECIM=1, y_in=511 then 767, 768, 255, 256 -> out_data=1, 1, 2, 0, 1; sat_flag=0.
- Saturation and flag clear: y_in=130815 -> 255 with sat_flag=0; y_in=130816 -> 255 with sat_flag=1. clr_flags=1 in the same cycle as a further saturating sample -> sat_flag stays 1. clr_flags alone -> sat_flag=0.
- Overflow: DECIM=1, out_ready=0, five samples 512, 1024, 1536, 2048, 2560 -> fifo_count=4, ovf_flag=1. Then out_ready=1 -> out_data=1, 2, 3, 4 in order, count drops to 0, out_valid=0.
- Pop while full: FIFO holding 4 entries, out_ready=1 while a new kept sample arrives at stage 2 -> fifo_count stays 4, no overflow, new sample appears last.
- Reset mid-operation: FIFO at 3 entries and phase=1, assert rst=0 asynchronously between edges -> out_valid=0, fifo_count=0 and flags=0 immediately. After release, the first in_valid sample is kept.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR output chain: sample width and the default
// decimation / requantisation / buffering parameters.
package fir_pkg;
    localparam int FIR_OUT_W = 17;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_SHIFT = 9;
    localparam int DEF_DECIM = 2;
    localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO for requantised samples. A push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int W     = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_q;
    // When empty, the slot just behind the read pointer still holds the last popped value.
    assign head    = empty ? mem_q[rd_ptr_q - 1'b1] : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fir_decim_requant.sv
// Decimates the FIR output stream, requantises kept samples with round-half-up
// and saturation, and buffers them behind a valid/ready output.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DECIM = DEF_DECIM,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    sat_flag,
    output logic                    ovf_flag,
    input  logic                    clr_flags
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IN_W:0] RND  = (SHIFT == 0) ? '0 :
                                     ((IN_W+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic [IN_W:0] MAXV = (IN_W+1)'((1 << OUT_W) - 1);

    logic [PW-1:0]    phase_q, phase_d;
    logic             pipe_valid_q, pipe_valid_d;
    logic [OUT_W-1:0] pipe_data_q, pipe_data_d;
    logic             sat_q, sat_d, ovf_q, ovf_d;
    logic             keep, sat_now, ovf_now;
    logic [IN_W:0]    sum, t;
    logic             fifo_full, fifo_empty;

    // Rounding add is one bit wider than the input so it can never wrap.
    assign sum     = {1'b0, y_in} + RND;
    assign t       = sum >> SHIFT;
    assign sat_now = (t > MAXV);
    assign keep    = in_valid && (phase_q == '0);

    // Output handshake: the head moves on a cycle where out_valid && out_ready
    // at the rising edge; out_valid never depends on out_ready.
    assign out_valid = !fifo_empty;
    assign ovf_now   = pipe_valid_q && fifo_full && !(out_ready && !fifo_empty);

    always_comb begin
        phase_d      = phase_q;
        pipe_valid_d = keep;
        pipe_data_d  = pipe_data_q;
        sat_d        = sat_q;
        ovf_d        = ovf_q;
        if (in_valid) phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        if (keep) pipe_data_d = sat_now ? '1 : t[OUT_W-1:0];
        // A set event in the same cycle as clr_flags wins.
        if (keep && sat_now) sat_d = 1'b1;
        else if (clr_flags)  sat_d = 1'b0;
        if (ovf_now)         ovf_d = 1'b1;
        else if (clr_flags)  ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q      <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            sat_q        <= sat_d;
            ovf_q        <= ovf_d;
        end
    end

    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid_q),
        .push_data (pipe_data_q),
        .pop       (out_ready),
        .head      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant: one DECIM=1 and one DECIM=2 instance
// share the same stimulus; each scenario checks the instance it targets.
module tb_fir_decim_requant;
    localparam int IN_W  = 17;
    localparam int OUT_W = 8;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  y_in;
    logic             out_ready;
    logic             clr_flags;

    logic             a_out_valid, b_out_valid;
    logic [OUT_W-1:0] a_out_data, b_out_data;
    logic [CW-1:0]    a_fifo_count, b_fifo_count;
    logic             a_sat_flag, b_sat_flag, a_ovf_flag, b_ovf_flag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fir_decim_requant #(.DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .fifo_count(a_fifo_count), .sat_flag(a_sat_flag), .ovf_flag(a_ovf_flag),
        .clr_flags(clr_flags)
    );

    fir_decim_requant #(.DECIM(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .fifo_count(b_fifo_count), .sat_flag(b_sat_flag), .ovf_flag(b_ovf_flag),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        rst       = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        y_in     = IN_W'(v);
        step();
        in_valid = 1'b0;
    endtask

    // DECIM=1 instance, out_ready=1: sample in, head visible after two edges, then popped.
    task automatic one_sample(input string tag, input int v, input int e);
        send(v);
        step();
        check_eq({tag, "_valid"}, a_out_valid, 1);
        check_eq({tag, "_data"}, a_out_data, e);
        step();
    endtask

    initial begin
        do_reset();
        check_eq("rst_valid", b_out_valid, 0);
        check_eq("rst_data", b_out_data, 0);
        check_eq("rst_count", b_fifo_count, 0);
        check_eq("rst_sat", b_sat_flag, 0);
        check_eq("rst_ovf", b_ovf_flag, 0);

        // Decimation by 2 with a free-running consumer.
        out_ready = 1'b1;
        in_valid = 1'b1; y_in = 17'd512;  step();
        check_eq("dec_e1_valid", b_out_valid, 0);
        y_in = 17'd1024; step();
        check_eq("dec_e2_valid", b_out_valid, 1);
        check_eq("dec_e2_data", b_out_data, 1);
        check_eq("dec_e2_count", b_fifo_count, 1);
        y_in = 17'd1536; step();
        check_eq("dec_e3_valid", b_out_valid, 0);
        y_in = 17'd2048; step();
        check_eq("dec_e4_valid", b_out_valid, 1);
        check_eq("dec_e4_data", b_out_data, 3);
        check_eq("dec_e4_count", b_fifo_count, 1);
        in_valid = 1'b0; step();
        check_eq("dec_e5_count", b_fifo_count, 0);

        // Round-half-up at the 1/2 LSB boundary.
        do_reset();
        out_ready = 1'b1;
        one_sample("rnd511", 511, 1);
        one_sample("rnd767", 767, 1);
        one_sample("rnd768", 768, 2);
        one_sample("rnd255", 255, 0);
        one_sample("rnd256", 256, 1);
        check_eq("rnd_sat", a_sat_flag, 0);
        check_eq("rnd_empty", a_out_valid, 0);

        // Saturation threshold, set-beats-clear, clear, and full-scale input.
        one_sample("sat130815", 130815, 255);
        check_eq("sat_below", a_sat_flag, 0);
        one_sample("sat130816", 130816, 255);
        check_eq("sat_set", a_sat_flag, 1);
        clr_flags = 1'b1;
        send(130816);
        clr_flags = 1'b0;
        check_eq("sat_set_wins", a_sat_flag, 1);
        step(); step();
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        check_eq("sat_cleared", a_sat_flag, 0);
        one_sample("sat_fullscale", 131071, 255);
        check_eq("sat_fullscale_flag", a_sat_flag, 1);

        // Overflow: five samples into a depth-4 FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; y_in = IN_W'(512 * (i + 1)); step();
        end
        in_valid = 1'b0; step();
        check_eq("ovf_count", a_fifo_count, 4);
        check_eq("ovf_flag", a_ovf_flag, 1);
        check_eq("ovf_sat", a_sat_flag, 0);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_drain_count", a_fifo_count, 32'(4 - i));
            check_eq("ovf_drain_data", a_out_data, exp_q.pop_front());
            step();
        end
        check_eq("ovf_end_count", a_fifo_count, 0);
        check_eq("ovf_end_valid", a_out_valid, 0);
        check_eq("ovf_end_hold", a_out_data, 4);

        // Pop while full: push of a fifth sample succeeds alongside a pop.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; y_in = IN_W'(512 * (i + 1)); step();
        end
        in_valid = 1'b0;
        check_eq("pwf_full", a_fifo_count, 4);
        out_ready = 1'b1;
        step();
        check_eq("pwf_count", a_fifo_count, 4);
        check_eq("pwf_ovf", a_ovf_flag, 0);
        for (int i = 2; i <= 5; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < 4; i++) begin
            check_eq("pwf_drain_data", a_out_data, exp_q.pop_front());
            step();
        end
        check_eq("pwf_end_count", a_fifo_count, 0);

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; y_in = IN_W'(512 * (i + 1)); step();
        end
        in_valid = 1'b0; step();
        check_eq("mid_pre_count", b_fifo_count, 3);
        check_eq("mid_pre_valid", b_out_valid, 1);
        check_eq("mid_pre_ovf1", a_ovf_flag, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", b_out_valid, 0);
        check_eq("mid_rst_count", b_fifo_count, 0);
        check_eq("mid_rst_data", b_out_data, 0);
        check_eq("mid_rst_ovf1", a_ovf_flag, 0);
        check_eq("mid_rst_count1", a_fifo_count, 0);
        #1 rst = 1'b1;
        send(1024);
        step();
        check_eq("mid_post_valid", b_out_valid, 1);
        check_eq("mid_post_data", b_out_data, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
